// File: rtl/button_pkg.sv
// ---------------------------------------------------------------------------
// button_pkg
// Shared definitions for the button press decoder:
//   - state_e         : per-channel state encoding (IDLE / PRESSED / LONG)
//   - *_CNT_DEFAULT   : default timing in clock cycles at 125 MHz
//   - cnt_width()     : width of the per-channel hold counter
// Optional feature macro: BUTTON_AUTOREPEAT_EN (affects counter sizing).
// ---------------------------------------------------------------------------
package button_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_e;

    localparam int LONG_CNT_DEFAULT   = 62_500_000;  // 0.5 s
    localparam int REPEAT_CNT_DEFAULT = 12_500_000;  // 0.1 s

    // The counter only ever holds values up to (threshold - 1), so $clog2 of
    // the largest active threshold is enough. The repeat threshold only
    // counts when auto-repeat is built in.
    function automatic int cnt_width(input int long_cnt, input int repeat_cnt,
                                     input bit with_repeat);
        int span;
        span = (with_repeat && (repeat_cnt > long_cnt)) ? repeat_cnt : long_cnt;
        return (span < 2) ? 1 : $clog2(span);
    endfunction

endpackage

// File: rtl/button_press_decoder_if.sv
// ---------------------------------------------------------------------------
// button_press_decoder_if
// Bundles the debounced button levels and the decoded event outputs.
//   debounced_signal : clean button levels (driver -> decoder)
//   press_pulse      : one-cycle pulse on press
//   release_pulse    : one-cycle pulse on release
//   long_pulse       : one-cycle pulse when the hold reaches LONG_CNT
//   repeat_pulse     : one-cycle auto-repeat pulse (0 without auto-repeat)
//   held             : high while a channel is pressed
// Modports: master = stimulus / debouncer side, slave = decoder side.
// ---------------------------------------------------------------------------
interface button_press_decoder_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] debounced_signal;
    logic [WIDTH-1:0] press_pulse;
    logic [WIDTH-1:0] release_pulse;
    logic [WIDTH-1:0] long_pulse;
    logic [WIDTH-1:0] repeat_pulse;
    logic [WIDTH-1:0] held;

    modport master (
        output debounced_signal,
        input  press_pulse, release_pulse, long_pulse, repeat_pulse, held
    );

    modport slave (
        input  debounced_signal,
        output press_pulse, release_pulse, long_pulse, repeat_pulse, held
    );
endinterface

// File: rtl/press_fsm.sv
// ---------------------------------------------------------------------------
// press_fsm
// Single-channel press classifier: 2-bit state plus one hold counter.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   debounced_signal : clean level of this button
//   press_pulse, release_pulse, long_pulse, repeat_pulse : registered pulses
//   held             : high while in PRESSED or LONG
// Macro BUTTON_AUTOREPEAT_EN: when defined, LONG emits repeat_pulse every
// REPEAT_CNT cycles; when undefined, LONG is silent and repeat_pulse is 0.
// ---------------------------------------------------------------------------
module press_fsm
    import button_pkg::*;
#(
    parameter int LONG_CNT   = LONG_CNT_DEFAULT,
    parameter int REPEAT_CNT = REPEAT_CNT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic debounced_signal,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

`ifdef BUTTON_AUTOREPEAT_EN
    localparam bit AUTOREPEAT = 1'b1;
`else
    localparam bit AUTOREPEAT = 1'b0;
`endif

    localparam int CW = cnt_width(LONG_CNT, REPEAT_CNT, AUTOREPEAT);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CNT - 1);
`ifdef BUTTON_AUTOREPEAT_EN
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CNT - 1);
`endif

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_d, release_d, long_d;
`ifdef BUTTON_AUTOREPEAT_EN
    logic          repeat_d, repeat_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
            repeat_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            long_pulse    <= long_d;
`ifdef BUTTON_AUTOREPEAT_EN
            repeat_q      <= repeat_d;
`endif
        end
    end

    // Release is tested before any threshold, so a low input always wins
    // over a count that happens to hit its limit on the same edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
        repeat_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // Level-triggered: a button already down out of reset
                // still produces a press.
                if (debounced_signal) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            PRESSED: begin
                if (!debounced_signal) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONG;
                    long_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LONG: begin
                if (!debounced_signal) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else begin
`ifdef BUTTON_AUTOREPEAT_EN
                    if (cnt_q == REPEAT_LAST) begin
                        repeat_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`else
                    cnt_d = '0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign held = (state_q != IDLE);

`ifdef BUTTON_AUTOREPEAT_EN
    assign repeat_pulse = repeat_q;
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/button_press_decoder.sv
// ---------------------------------------------------------------------------
// button_press_decoder
// WIDTH independent press classifiers, one press_fsm per button channel.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : button_press_decoder_if.slave (debounced_signal in;
//              press/release/long/repeat pulses and held out)
// Macro BUTTON_AUTOREPEAT_EN enables auto-repeat pulses in LONG.
// ---------------------------------------------------------------------------
module button_press_decoder
    import button_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int LONG_CNT   = LONG_CNT_DEFAULT,
    parameter int REPEAT_CNT = REPEAT_CNT_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    button_press_decoder_if.slave       bus
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        press_fsm #(
            .LONG_CNT   (LONG_CNT),
            .REPEAT_CNT (REPEAT_CNT)
        ) u_fsm (
            .clk              (clk),
            .rst              (rst),
            .debounced_signal (bus.debounced_signal[i]),
            .press_pulse      (bus.press_pulse[i]),
            .release_pulse    (bus.release_pulse[i]),
            .long_pulse       (bus.long_pulse[i]),
            .repeat_pulse     (bus.repeat_pulse[i]),
            .held             (bus.held[i])
        );
    end

endmodule

// File: tb/tb_button_press_decoder.sv
// ---------------------------------------------------------------------------
// tb_button_press_decoder
// Directed scenarios plus randomized levels/resets, every cycle compared
// against a hold-length model (edges since the first high sample).
// ---------------------------------------------------------------------------
module tb_button_press_decoder;

    localparam int W    = 2;
    localparam int LONG = 8;
    localparam int REP  = 4;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    button_press_decoder_if #(.WIDTH(W)) bus ();

    button_press_decoder #(
        .WIDTH      (W),
        .LONG_CNT   (LONG),
        .REPEAT_CNT (REP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // model: number of consecutive high samples seen per channel
    int       hold_len [W];
    logic [W-1:0] exp_press, exp_rel, exp_long, exp_rep, exp_held;

    // observed pulse tallies for directed scenarios
    int cnt_press [W], cnt_rel [W], cnt_long [W], cnt_rep [W];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic [W-1:0] din, input logic r);
        exp_press = '0; exp_rel = '0; exp_long = '0; exp_rep = '0;
        for (int c = 0; c < W; c++) begin
            if (r) begin
                hold_len[c] = 0;
            end else if (din[c]) begin
                // n = edges elapsed since E0 for this channel
                int n;
                n = hold_len[c];
                if (n == 0) exp_press[c] = 1'b1;
                if (n == LONG) exp_long[c] = 1'b1;
                if (AR && n > LONG && ((n - LONG) % REP) == 0) exp_rep[c] = 1'b1;
                hold_len[c]++;
            end else begin
                if (hold_len[c] > 0) exp_rel[c] = 1'b1;
                hold_len[c] = 0;
            end
            exp_held[c] = (hold_len[c] > 0);
        end
    endtask

    task automatic step(input logic [W-1:0] din, input logic r);
        @(negedge clk);
        bus.debounced_signal = din;
        rst = r;
        @(posedge clk);
        model_edge(din, r);
        #1;
        chk("press",   32'(bus.press_pulse),   32'(exp_press));
        chk("release", 32'(bus.release_pulse), 32'(exp_rel));
        chk("long",    32'(bus.long_pulse),    32'(exp_long));
        chk("repeat",  32'(bus.repeat_pulse),  32'(exp_rep));
        chk("held",    32'(bus.held),          32'(exp_held));
        for (int c = 0; c < W; c++) begin
            cnt_press[c] += int'(bus.press_pulse[c]);
            cnt_rel[c]   += int'(bus.release_pulse[c]);
            cnt_long[c]  += int'(bus.long_pulse[c]);
            cnt_rep[c]   += int'(bus.repeat_pulse[c]);
        end
    endtask

    task automatic clr_tally();
        for (int c = 0; c < W; c++) begin
            cnt_press[c] = 0; cnt_rel[c] = 0; cnt_long[c] = 0; cnt_rep[c] = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b0);
    endtask

    initial begin
        for (int c = 0; c < W; c++) hold_len[c] = 0;
        bus.debounced_signal = '0;

        // reset state
        for (int i = 0; i < 3; i++) step('0, 1'b1);
        idle(2);

        // short press: high E0..E4, low at E5
        clr_tally();
        for (int i = 0; i < 5; i++) step(2'b01, 1'b0);
        idle(3);
        chk("short.press", 32'(cnt_press[0]), 32'd1);
        chk("short.rel",   32'(cnt_rel[0]),   32'd1);
        chk("short.long",  32'(cnt_long[0]),  32'd0);
        chk("short.rep",   32'(cnt_rep[0]),   32'd0);

        // long hold: high E0..E19, low at E20
        clr_tally();
        for (int i = 0; i < 20; i++) step(2'b01, 1'b0);
        idle(3);
        chk("longhold.long", 32'(cnt_long[0]), 32'd1);
        chk("longhold.rep",  32'(cnt_rep[0]),  AR ? 32'd2 : 32'd0);
        chk("longhold.rel",  32'(cnt_rel[0]),  32'd1);

        // threshold collision: high E0..E7, low at E8
        clr_tally();
        for (int i = 0; i < 8; i++) step(2'b01, 1'b0);
        idle(3);
        chk("collide.long", 32'(cnt_long[0]), 32'd0);
        chk("collide.rel",  32'(cnt_rel[0]),  32'd1);

        // channel independence: ch1 rises 3 edges after ch0, each held 12
        clr_tally();
        for (int k = 0; k < 15; k++) begin
            logic [W-1:0] d;
            d[0] = (k < 12);
            d[1] = (k >= 3);
            step(d, 1'b0);
        end
        idle(3);
        chk("indep.long0", 32'(cnt_long[0]), 32'd1);
        chk("indep.long1", 32'(cnt_long[1]), 32'd1);
        chk("indep.rel1",  32'(cnt_rel[1]),  32'd1);

        // reset mid-hold at E10 with input kept high
        clr_tally();
        for (int i = 0; i < 10; i++) step(2'b01, 1'b0);
        step(2'b01, 1'b1);
        for (int i = 0; i < 12; i++) step(2'b01, 1'b0);
        idle(3);
        chk("rstmid.press", 32'(cnt_press[0]), 32'd2);
        chk("rstmid.rel",   32'(cnt_rel[0]),   32'd1);
        chk("rstmid.long",  32'(cnt_long[0]),  32'd2);

        // randomized levels with occasional resets
        begin
            logic [W-1:0] lvl;
            int           run [W];
            lvl = '0;
            for (int c = 0; c < W; c++) run[c] = 1;
            for (int cyc = 0; cyc < 4000; cyc++) begin
                logic r;
                for (int c = 0; c < W; c++) begin
                    run[c]--;
                    if (run[c] <= 0) begin
                        lvl[c] = ~lvl[c];
                        // mix short taps, near-threshold holds and long holds
                        case ($urandom_range(3, 0))
                            0:       run[c] = int'($urandom_range(3, 1));
                            1:       run[c] = int'($urandom_range(LONG + 1, LONG - 1));
                            2:       run[c] = int'($urandom_range(LONG + 3 * REP + 1, LONG + REP - 1));
                            default: run[c] = int'($urandom_range(30, 1));
                        endcase
                    end
                end
                r = ($urandom_range(199, 0) == 0);
                step(lvl, r);
            end
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
